// File: rtl/as_ethernet_header_writer_32bit.sv
// as_ethernet_header_writer_32bit
// Overwrites the 14-byte Ethernet header of each packet with destination MAC,
// source MAC and (optionally) ethertype supplied on a side interface.
// Module-header words and payload pass through. One register stage with
// full rdy back-pressure.
//
// Build option: define AS_ETH_WRITER_ETHERTYPE_EN to also rewrite the
// ethertype; when undefined only the MAC addresses are replaced.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for hdr_valid and first word; captures header
// WORD_1   | forwarding module headers, next data word gets dst[47:16]
// WORD_2   | next word gets {dst[15:0], src[47:32]}
// WORD_3   | next word gets src[31:0]
// WORD_4   | next word gets {ethertype, in_data[15:0]}
// WAIT_EOP | payload pass-through until EOP
module as_ethernet_header_writer_32bit #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  input  logic [47:0]           hdr_dst_mac,
  input  logic [47:0]           hdr_src_mac,
  input  logic [15:0]           hdr_ethertype,
  input  logic                  hdr_valid,
  output logic                  hdr_ack,
  output logic [15:0]           pkt_count
);

  typedef enum logic [5:0] {
    IDLE     = 6'b000001,
    WORD_1   = 6'b000010,
    WORD_2   = 6'b000100,
    WORD_3   = 6'b001000,
    WORD_4   = 6'b010000,
    WAIT_EOP = 6'b100000
  } state_t;

  state_t state, state_nxt;

  logic [47:0] dst_q, src_q;
  logic [47:0] cur_dst, cur_src;
  logic        accept, is_ctrl, in_idle, eop;
  logic [DATA_WIDTH-1:0] data_nxt;

  assign in_idle = (state == IDLE);
  assign in_rdy  = out_rdy && (!in_idle || hdr_valid);
  assign accept  = in_wr && in_rdy;
  assign is_ctrl = |in_ctrl;

  // In IDLE the header is captured in the same cycle it is used, so take it
  // straight from the side interface rather than the not-yet-loaded latch.
  assign cur_dst = in_idle ? hdr_dst_mac : dst_q;
  assign cur_src = in_idle ? hdr_src_mac : src_q;

`ifdef AS_ETH_WRITER_ETHERTYPE_EN
  logic [15:0] et_q;
  logic [15:0] cur_et;
  assign cur_et = in_idle ? hdr_ethertype : et_q;
`else
  logic unused_ethertype;
  assign unused_ethertype = ^hdr_ethertype;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: advance only on an accepted word; any ctrl word after data is EOP
  always_comb begin
    state_nxt = state;
    if (accept) begin
      case (state)
        IDLE, WORD_1: state_nxt = is_ctrl ? WORD_1 : WORD_2;
        WORD_2:       state_nxt = is_ctrl ? IDLE : WORD_3;
        WORD_3:       state_nxt = is_ctrl ? IDLE : WORD_4;
        WORD_4:       state_nxt = is_ctrl ? IDLE : WAIT_EOP;
        WAIT_EOP:     state_nxt = is_ctrl ? IDLE : WAIT_EOP;
        default:      state_nxt = IDLE;
      endcase
    end
  end

  // Output word selection and EOP detection for the word being accepted
  always_comb begin
    data_nxt = in_data;
    eop      = 1'b0;
    case (state)
      IDLE, WORD_1: if (!is_ctrl) data_nxt = cur_dst[47:16];
      WORD_2: begin
        data_nxt = {cur_dst[15:0], cur_src[47:32]};
        eop      = is_ctrl;
      end
      WORD_3: begin
        data_nxt = cur_src[31:0];
        eop      = is_ctrl;
      end
      WORD_4: begin
`ifdef AS_ETH_WRITER_ETHERTYPE_EN
        data_nxt = {cur_et, in_data[15:0]};
`endif
        eop      = is_ctrl;
      end
      WAIT_EOP: eop = is_ctrl;
      default: ;
    endcase
  end

  // Output registers, hold while downstream is stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data <= '0;
      out_ctrl <= '0;
      out_wr   <= 1'b0;
      hdr_ack  <= 1'b0;
    end else begin
      hdr_ack <= accept && in_idle;
      if (out_rdy) begin
        out_wr <= accept;
        if (accept) begin
          out_data <= data_nxt;
          out_ctrl <= in_ctrl;
        end
      end
    end
  end

  // Header latch (captured on the first word of a packet) and packet counter
  always_ff @(posedge clk) begin
    if (reset) begin
      dst_q     <= '0;
      src_q     <= '0;
`ifdef AS_ETH_WRITER_ETHERTYPE_EN
      et_q      <= '0;
`endif
      pkt_count <= '0;
    end else begin
      if (accept && in_idle) begin
        dst_q <= hdr_dst_mac;
        src_q <= hdr_src_mac;
`ifdef AS_ETH_WRITER_ETHERTYPE_EN
        et_q  <= hdr_ethertype;
`endif
      end
      if (accept && eop) pkt_count <= pkt_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_as_ethernet_header_writer_32bit.sv
// Testbench for as_ethernet_header_writer_32bit. Expected output words are
// built from a byte image of the 14-byte Ethernet header; a compare process
// checks every word the downstream side takes.
module tb_as_ethernet_header_writer_32bit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] in_data = '0;
  logic [3:0]  in_ctrl = '0;
  logic        in_wr = 1'b0;
  logic        in_rdy;
  logic [31:0] out_data;
  logic [3:0]  out_ctrl;
  logic        out_wr;
  logic        out_rdy = 1'b1;
  logic [47:0] hdr_dst_mac = '0;
  logic [47:0] hdr_src_mac = '0;
  logic [15:0] hdr_ethertype = '0;
  logic        hdr_valid = 1'b0;
  logic        hdr_ack;
  logic [15:0] pkt_count;

  as_ethernet_header_writer_32bit dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
    .hdr_dst_mac(hdr_dst_mac), .hdr_src_mac(hdr_src_mac),
    .hdr_ethertype(hdr_ethertype), .hdr_valid(hdr_valid), .hdr_ack(hdr_ack),
    .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  c;
    bit          first;
  } exp_t;

  exp_t        expq[$];
  logic [31:0] seen[$];
  logic [3:0]  seen_c[$];
  logic [31:0] pw[8];
  logic [3:0]  pc[8];
  logic [15:0] model_cnt = '0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_ack = 0;
  int          n_pkt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Downstream side: every word taken must match the head of the model queue
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (hdr_ack) n_ack++;
      if (out_wr && out_rdy) begin
        if (expq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_word: got %h with no word expected", out_data);
        end else begin
          e = expq.pop_front();
          chk("out_data", out_data, e.d);
          chk("out_ctrl", {28'd0, out_ctrl}, {28'd0, e.c});
          chk("hdr_ack_with_first", {31'd0, hdr_ack}, {31'd0, e.first});
          seen.push_back(out_data);
          seen_c.push_back(out_ctrl);
        end
      end else if (hdr_ack) begin
        n_cmp++;
        n_err++;
        $display("FAIL hdr_ack_alone: got 1 expected 0 without a fresh word");
      end
    end
  end

  task automatic send_word(input logic [31:0] d, input logic [3:0] c, output bit acc);
    in_data = d;
    in_ctrl = c;
    in_wr   = 1'b1;
    acc     = 1'b0;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      acc = in_rdy;
      tick();
    end
    in_wr = 1'b0;
    if (!acc) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: got in_rdy 0 for 50 cycles expected 1");
    end
  endtask

  // Sends pw/pc[0..n-1]; stall_idx drops out_rdy for 3 cycles before that word.
  // chain presents the next packet's header right after this one is captured;
  // otherwise the header lines are scrambled to prove they are latched.
  task automatic send_pkt(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] et,
                          input int n, input int stall_idx, input bit chain,
                          input logic [47:0] nd, input logic [47:0] ns, input logic [15:0] net);
    logic [7:0] hb[14];
    bit   started;
    bit   acc;
    int   k;
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      hb[i]     = dst[47-8*i -: 8];
      hb[6 + i] = src[47-8*i -: 8];
    end
    hb[12] = et[15:8];
    hb[13] = et[7:0];
    hdr_dst_mac   = dst;
    hdr_src_mac   = src;
    hdr_ethertype = et;
    hdr_valid     = 1'b1;
    n_pkt++;
    started = 1'b0;
    k = 0;
    for (int i = 0; i < n; i++) begin
      if (i == stall_idx) begin
        in_data = pw[i];
        in_ctrl = pc[i];
        in_wr   = 1'b1;
        out_rdy = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          chk("stall_in_rdy", {31'd0, in_rdy}, 32'd0);
          chk("stall_out_wr", {31'd0, out_wr}, 32'd1);
          if (expq.size() > 0) chk("stall_out_data", out_data, expq[0].d);
          tick();
        end
        out_rdy = 1'b1;
      end
      send_word(pw[i], pc[i], acc);
      if (acc) begin
        e.first = (i == 0);
        e.c     = pc[i];
        if (!started && pc[i] != 4'd0) begin
          e.d = pw[i];
        end else begin
          started = 1'b1;
          if (k < 3) e.d = {hb[4*k], hb[4*k+1], hb[4*k+2], hb[4*k+3]};
`ifdef AS_ETH_WRITER_ETHERTYPE_EN
          else if (k == 3) e.d = {hb[12], hb[13], pw[i][15:0]};
`endif
          else e.d = pw[i];
          if (pc[i] != 4'd0 && k > 0) model_cnt++;
          k++;
        end
        expq.push_back(e);
      end
      if (i == 0) begin
        if (chain) begin
          hdr_dst_mac   = nd;
          hdr_src_mac   = ns;
          hdr_ethertype = net;
        end else begin
          hdr_valid     = 1'b0;
          hdr_dst_mac   = ~dst;
          hdr_src_mac   = ~src;
          hdr_ethertype = ~et;
        end
      end
    end
  endtask

  task automatic drain_and_check_count(input string name);
    for (int t = 0; t < 30 && expq.size() != 0; t++) @(negedge clk);
    @(negedge clk);
    chk({name, "_drained"}, expq.size(), 32'd0);
    chk({name, "_pkt_count"}, {16'd0, pkt_count}, {16'd0, model_cnt});
    tick();
  endtask

  task automatic load_basic();
    pw = '{32'h00040003, 32'h11111111, 32'h22222222, 32'h33333333,
           32'h4444ABCD, 32'h55555555, 32'h0, 32'h0};
    pc = '{4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0};
  endtask

  task automatic check_basic_literals(input string name);
    logic [31:0] w4;
`ifdef AS_ETH_WRITER_ETHERTYPE_EN
    w4 = 32'h0800ABCD;
`else
    w4 = 32'h4444ABCD;
`endif
    chk({name, "_count"}, seen.size(), 32'd6);
    if (seen.size() == 6) begin
      chk({name, "_modhdr"}, seen[0], 32'h00040003);
      chk({name, "_w1"}, seen[1], 32'h00112233);
      chk({name, "_w2"}, seen[2], 32'h4455AABB);
      chk({name, "_w3"}, seen[3], 32'hCCDDEEFF);
      chk({name, "_w4"}, seen[4], w4);
      chk({name, "_eop"}, seen[5], 32'h55555555);
      chk({name, "_eop_ctrl"}, {28'd0, seen_c[5]}, 32'h8);
    end
  endtask

  localparam logic [47:0] DST = 48'h001122334455;
  localparam logic [47:0] SRC = 48'hAABBCCDDEEFF;
  localparam logic [15:0] ET  = 16'h0800;

  initial begin
    // reset
    tick();
    tick();
    @(negedge clk);
    chk("rst_out_wr", {31'd0, out_wr}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_ctrl", {28'd0, out_ctrl}, 32'd0);
    chk("rst_hdr_ack", {31'd0, hdr_ack}, 32'd0);
    chk("rst_pkt_count", {16'd0, pkt_count}, 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("idle_in_rdy_no_hdr", {31'd0, in_rdy}, 32'd0);
    tick();

    // basic rewrite
    load_basic();
    seen.delete(); seen_c.delete();
    send_pkt(DST, SRC, ET, 6, -1, 1'b0, '0, '0, '0);
    drain_and_check_count("basic");
    check_basic_literals("basic");
    chk("basic_pkt_count_lit", {16'd0, pkt_count}, 32'd1);
    chk("basic_ack_count", n_ack, 32'd1);

    // no header: word pending but blocked until hdr_valid
    hdr_valid = 1'b0;
    in_data = 32'h00040003; in_ctrl = 4'hF; in_wr = 1'b1;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      chk("nohdr_in_rdy", {31'd0, in_rdy}, 32'd0);
      chk("nohdr_out_wr", {31'd0, out_wr}, 32'd0);
      tick();
    end
    seen.delete(); seen_c.delete();
    send_pkt(DST, SRC, ET, 6, -1, 1'b0, '0, '0, '0);
    drain_and_check_count("nohdr");
    check_basic_literals("nohdr");

    // back-pressure in WORD_3
    seen.delete(); seen_c.delete();
    send_pkt(DST, SRC, ET, 6, 3, 1'b0, '0, '0, '0);
    drain_and_check_count("bp");
    check_basic_literals("bp");

    // short packet
    pw = '{32'h11111111, 32'h22222222, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    pc = '{4'h0, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    seen.delete(); seen_c.delete();
    send_pkt(DST, SRC, ET, 2, -1, 1'b0, '0, '0, '0);
    drain_and_check_count("short");
    chk("short_count", seen.size(), 32'd2);
    if (seen.size() == 2) begin
      chk("short_w1", seen[0], 32'h00112233);
      chk("short_w2", seen[1], 32'h4455AABB);
      chk("short_ctrl", {28'd0, seen_c[1]}, 32'h4);
    end
    chk("short_pkt_count_lit", {16'd0, pkt_count}, 32'd4);
    @(negedge clk);
    chk("short_back_to_idle", {31'd0, in_rdy}, 32'd0);
    tick();

    // back-to-back packets with different headers
    pw = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44445555,
           32'h66666666, 32'h0, 32'h0, 32'h0};
    pc = '{4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0};
    seen.delete(); seen_c.delete();
    send_pkt(48'h0A0B0C0D0E0F, 48'h102030405060, 16'h86DD, 5, -1, 1'b1,
             48'hDEADBEEF0001, 48'h0200000000AA, 16'h0806);
    pw = '{32'h12345678, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC,
           32'hDDDD1234, 32'hEEEEEEEE, 32'h0, 32'h0};
    pc = '{4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0};
    send_pkt(48'hDEADBEEF0001, 48'h0200000000AA, 16'h0806, 6, -1, 1'b0, '0, '0, '0);
    drain_and_check_count("b2b");
    chk("b2b_count", seen.size(), 32'd11);
    if (seen.size() == 11) begin
      chk("b2b_a_w1", seen[0], 32'h0A0B0C0D);
      chk("b2b_b_w1", seen[6], 32'hDEADBEEF);
      chk("b2b_b_w2", seen[7], 32'h00010200);
      chk("b2b_b_w3", seen[8], 32'h000000AA);
`ifdef AS_ETH_WRITER_ETHERTYPE_EN
      chk("b2b_b_w4", seen[9], 32'h08061234);
`else
      chk("b2b_b_w4", seen[9], 32'hDDDD1234);
`endif
    end

    // counter wrap: jump the counter to its last value instead of
    // streaming 65535 packets through
    force dut.pkt_count = 16'hFFFF;
    tick();
    release dut.pkt_count;
    model_cnt = 16'hFFFF;
    pw = '{32'h11111111, 32'h22222222, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    pc = '{4'h0, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    send_pkt(DST, SRC, ET, 2, -1, 1'b0, '0, '0, '0);
    drain_and_check_count("wrap");
    chk("wrap_pkt_count_lit", {16'd0, pkt_count}, 32'd0);

    // reset while in WAIT_EOP
    pw = '{32'h00040003, 32'h11111111, 32'h22222222, 32'h33333333,
           32'h4444ABCD, 32'h55555555, 32'h0, 32'h0};
    pc = '{4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    send_pkt(DST, SRC, ET, 6, -1, 1'b0, '0, '0, '0);
    for (int t = 0; t < 30 && expq.size() != 0; t++) @(negedge clk);
    tick();
    in_data = 32'h77777777; in_ctrl = 4'h0; in_wr = 1'b1;
    reset = 1'b1;
    expq.delete();
    model_cnt = '0;
    tick();
    in_wr = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_wr", {31'd0, out_wr}, 32'd0);
    chk("mid_rst_out_data", out_data, 32'd0);
    chk("mid_rst_out_ctrl", {28'd0, out_ctrl}, 32'd0);
    chk("mid_rst_hdr_ack", {31'd0, hdr_ack}, 32'd0);
    chk("mid_rst_pkt_count", {16'd0, pkt_count}, 32'd0);
    chk("mid_rst_idle", {31'd0, in_rdy}, 32'd0);
    tick();
    reset = 1'b0;
    load_basic();
    seen.delete(); seen_c.delete();
    send_pkt(DST, SRC, ET, 6, -1, 1'b0, '0, '0, '0);
    drain_and_check_count("post_rst");
    check_basic_literals("post_rst");
    chk("post_rst_pkt_count_lit", {16'd0, pkt_count}, 32'd1);

    chk("final_ack_count", n_ack, n_pkt);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
